// File: rtl/mixcol_pkg.sv
// mixcol_pkg: shared types, GF(2^8) constants and helpers for the
// MixColumns engine.
package mixcol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] GF_POLY = 8'h1b;

  // Byte k holds the coefficient applied to input row (k + out_row) mod 4.
  localparam logic [31:0] FWD_COEF = 32'h01010302;
  localparam logic [31:0] INV_COEF = 32'h090d0b0e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (GF_POLY & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                     input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One column times the rotated coefficient matrix.
  function automatic logic [31:0] mix_col(input logic [31:0] a,
                                          input logic [31:0] coef);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[8*i +: 8] = r[8*i +: 8] ^
          gmul(a[8*j +: 8], coef[8*((j - i) & 3) +: 8]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mixcol_engine_column.sv
// mixcol_column: combinational single-column (Inv)MixColumns.
// Inverse path only exists when MIXCOL_INV_EN is defined.
module mixcol_column
  import mixcol_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);

  logic [31:0] w_fwd;

  assign w_fwd = mix_col(i_col, FWD_COEF);

`ifdef MIXCOL_INV_EN
  logic [31:0] w_inv;

  assign w_inv = mix_col(i_col, INV_COEF);
  assign o_col = i_inv ? w_inv : w_fwd;
`else
  logic w_unused_inv;

  assign w_unused_inv = i_inv;
  assign o_col = w_fwd;
`endif

endmodule

// File: rtl/mixcol_engine.sv
// mixcol_engine: multi-beat AES (Inv)MixColumns over a 128-bit state.
// Define MIXCOL_INV_EN to build the inverse datapath and honour in_inv.
module mixcol_engine
  import mixcol_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4,
  parameter int OUT_REG        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BEATS = 4 / COLS_PER_CYCLE;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e       r_state;
  logic [1:0]   r_beat;
  logic [127:0] r_work;
  logic         r_inv;
  logic         r_out_valid;

  logic         w_acc;
  logic         w_last;
  logic         w_inv_in;
  logic [127:0] w_work_nxt;
  logic [1:0]   w_ci   [COLS_PER_CYCLE];
  logic [31:0]  w_cin  [COLS_PER_CYCLE];
  logic [31:0]  w_cout [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  assign w_inv_in = in_inv;
`else
  logic w_unused_inv;

  assign w_unused_inv = in_inv;
  assign w_inv_in     = 1'b0;
`endif

  assign in_ready  = (r_state == ST_IDLE) ||
                     (r_state == ST_DONE && r_out_valid && out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_last    = (r_beat == 2'(BEATS - 1));
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);

  for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_col
    assign w_ci[c]  = 2'(int'(r_beat) * COLS_PER_CYCLE + c);
    assign w_cin[c] = r_work[{w_ci[c], 5'd0} +: 32];

    mixcol_column u_col (
      .i_col (w_cin[c]),
      .i_inv (r_inv),
      .o_col (w_cout[c])
    );
  end

  // Write this beat's transformed columns back into the working state
  always_comb begin
    w_work_nxt = r_work;
    for (int c = 0; c < COLS_PER_CYCLE; c++) begin
      w_work_nxt[{w_ci[c], 5'd0} +: 32] = w_cout[c];
    end
  end

  // Control FSM, beat counter, working state and captured mode.
  // out_valid rises one cycle after entering DONE so the result
  // can be registered before it is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_work      <= '0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_state <= ST_CALC;
            r_work  <= in_data;
            r_inv   <= w_inv_in;
          end
        end
        ST_CALC: begin
          r_work <= w_work_nxt;
          if (w_last) begin
            r_state <= ST_DONE;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_acc) begin
              r_state <= ST_CALC;
              r_work  <= in_data;
              r_inv   <= w_inv_in;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [127:0] r_out;

    // Capture the finished state as DONE is entered
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out <= '0;
      end else if (r_state == ST_DONE && !r_out_valid) begin
        r_out <= r_work;
      end
    end

    assign out_data = r_out;
  end else begin : g_ocomb
    assign out_data = r_work;
  end

endmodule

// File: tb/tb_mixcol_engine.sv
// tb_mixcol_engine: directed checks of mixcol_engine at
// COLS_PER_CYCLE 4, 2 and 1 driven in lockstep.
module tb_mixcol_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [2:0]   rdy;
  logic [2:0]   ov;
  logic [2:0]   bsy;
  logic [127:0] od [3];

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] C01 = 32'h01010101;
  localparam logic [31:0] CC6 = 32'hc6c6c6c6;
  localparam logic [31:0] VA  = 32'h455313db;
  localparam logic [31:0] RA  = 32'hbca14d8e;
  localparam logic [31:0] VB  = 32'h5c220af2;
  localparam logic [31:0] RB  = 32'h9d58dc9f;

  always #5 clk = ~clk;

  mixcol_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));

  mixcol_engine #(.COLS_PER_CYCLE(2), .OUT_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));

  mixcol_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] d, input logic inv,
                           input logic [127:0] exp, input bit chk,
                           input string name,
                           output logic [127:0] res);
    int n;
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("FAIL %s idle: in_ready=%b want 111", name, rdy);
    end
    in_data = d;
    in_inv = inv;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_inv = ~inv;
    in_data = ~d;
    n = 0;
    while (ov !== 3'b111 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (ov !== 3'b111) begin
      failures++;
      $display("FAIL %s timeout: out_valid=%b want 111", name, ov);
    end
    res = od[0];
    if (chk) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (od[k] !== exp) begin
          failures++;
          $display("FAIL %s dut%0d: got %h want %h", name, k, od[k], exp);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ov !== 3'b000 || bsy !== 3'b000 || od[0] !== '0 ||
        od[1] !== '0 || od[2] !== '0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b busy=%b want 000/000, data zero",
               ov, bsy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b want 111", rdy);
    end
  endtask

  task automatic test_fixed_points();
    logic [127:0] d;
    int lat [3];
    for (int p = 0; p < 2; p++) begin
      d = (p == 0) ? {4{C01}} : {4{CC6}};
      in_data = d;
      in_valid = 1'b1;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (bsy !== 3'b111 || ov !== 3'b000) begin
        failures++;
        $display("FAIL fixed%0d calc: busy=%b out_valid=%b want 111/000",
                 p, bsy, ov);
      end
      for (int k = 0; k < 3; k++) lat[k] = 0;
      for (int n = 1; n <= 8; n++) begin
        tick();
        for (int k = 0; k < 3; k++) begin
          if (ov[k] && lat[k] == 0) lat[k] = n;
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lat[k] != lat_of(k)) begin
          failures++;
          $display("FAIL fixed%0d latency dut%0d: got %0d want %0d",
                   p, k, lat[k], lat_of(k));
        end
        checks++;
        if (od[k] !== d) begin
          failures++;
          $display("FAIL fixed%0d data dut%0d: got %h want %h",
                   p, k, od[k], d);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_forward();
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] r;
    for (int v = 0; v < 2; v++) begin
      for (int pos = 0; pos < 4; pos++) begin
        d = {4{C01}};
        e = {4{C01}};
        d[32*pos +: 32] = (v == 0) ? VA : VB;
        e[32*pos +: 32] = (v == 0) ? RA : RB;
        run_block(d, 1'b0, e, 1'b1, $sformatf("fwd_v%0d_p%0d", v, pos), r);
      end
    end
    run_block({VB, VA, CC6, C01}, 1'b0, {RB, RA, CC6, C01}, 1'b1,
              "fwd_mixed", r);
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] mid;
    logic [127:0] r;
    for (int pos = 0; pos < 4; pos++) begin
      d = {4{CC6}};
      e = {4{CC6}};
      d[32*pos +: 32] = RA;
      e[32*pos +: 32] = VA;
      run_block(d, 1'b1, e, 1'b1, $sformatf("inv_p%0d", pos), r);
    end
    for (int t = 0; t < 3; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_block(d, 1'b0, '0, 1'b0, "rt_fwd", mid);
      run_block(mid, 1'b1, d, 1'b1, $sformatf("round_trip%0d", t), r);
    end
  endtask
`else
  task automatic test_no_inverse();
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] r;
    for (int pos = 0; pos < 4; pos++) begin
      d = {4{C01}};
      e = {4{C01}};
      d[32*pos +: 32] = VA;
      e[32*pos +: 32] = RA;
      run_block(d, 1'b1, e, 1'b1, $sformatf("noinv_p%0d", pos), r);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [127:0] d1;
    logic [127:0] e1;
    logic [127:0] d2;
    logic [127:0] e2;
    int n;
    d1 = {VA, VB, C01, CC6};
    e1 = {RA, RB, C01, CC6};
    d2 = {4{VB}};
    e2 = {4{RB}};
    in_data = d1;
    in_inv = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (ov !== 3'b111 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (ov !== 3'b111) begin
      failures++;
      $display("FAIL b2b timeout: out_valid=%b want 111", ov);
    end
    in_valid = 1'b1;
    in_data = d2;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (ov !== 3'b111 || rdy !== 3'b000 || od[0] !== e1 ||
          od[1] !== e1 || od[2] !== e1) begin
        failures++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b d0=%h want 111/000 %h",
                 c, ov, rdy, od[0], e1);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("FAIL b2b ready: in_ready=%b want 111", rdy);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ov !== 3'b000 || bsy !== 3'b111) begin
      failures++;
      $display("FAIL b2b accept: out_valid=%b busy=%b want 000/111", ov, bsy);
    end
    n = 0;
    while (ov !== 3'b111 && n < 10) begin
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (od[k] !== e2 || ov[k] !== 1'b1) begin
        failures++;
        $display("FAIL b2b second dut%0d: got %h valid=%b want %h",
                 k, od[k], ov[k], e2);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    in_data = {4{VA}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 3'b000 || bsy !== 3'b000 || od[0] !== '0 ||
        od[1] !== '0 || od[2] !== '0) begin
      failures++;
      $display("FAIL midcalc_reset: out_valid=%b busy=%b want 000/000", ov, bsy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("FAIL midcalc_ready: in_ready=%b want 111", rdy);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ov !== 3'b000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midcalc_no_output: out_valid rose got 1 want 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_points();
    test_forward();
`ifdef MIXCOL_INV_EN
    test_inverse();
`else
    test_no_inverse();
`endif
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
